led_pattern_gen: RTL and testbench



---
 rtl/led_pattern_gen.sv | 194 +++++++++++++++++++
 tb/tb_led_pattern_gen.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: OFF / ON / BLINK / CODE / BREATHE per channel.
// Optional LED_DIM_EN adds a global PWM dim input gating every channel.
module led_pattern_gen #(
    parameter int unsigned CLK_FREQ_HZ    = 50_000_000,
    parameter int unsigned TICK_HZ        = 1000,
    parameter int unsigned LED_NUM        = 4,
    parameter int unsigned PWM_BITS       = 8,
    parameter int unsigned CODE_ON_TICKS  = 200,
    parameter int unsigned CODE_GAP_TICKS = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_wr,
    input  logic [3:0]          cfg_idx,
    input  logic [2:0]          cfg_mode,
    input  logic [15:0]         cfg_arg,
`ifdef LED_DIM_EN
    input  logic [PWM_BITS-1:0] dim,
`endif
    output logic                cfg_ack,
    output logic [LED_NUM-1:0]  led
);

    localparam int unsigned TICK_DIV = CLK_FREQ_HZ / TICK_HZ;
    localparam int unsigned PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CNT_W    = 16;

    localparam logic [2:0] MODE_ON      = 3'd1;
    localparam logic [2:0] MODE_BLINK   = 3'd2;
    localparam logic [2:0] MODE_CODE    = 3'd3;
    localparam logic [2:0] MODE_BREATHE = 3'd4;

    localparam logic [1:0] PH_ON  = 2'd0;
    localparam logic [1:0] PH_OFF = 2'd1;
    localparam logic [1:0] PH_GAP = 2'd2;

    localparam logic [CNT_W-1:0]    ON_T     = CNT_W'(CODE_ON_TICKS);
    localparam logic [CNT_W-1:0]    GAP_T    = CNT_W'(CODE_GAP_TICKS);
    localparam logic [PWM_BITS-1:0] DUTY_TOP = '1;

    logic [PRE_W-1:0]    pre_q, pre_d;
    logic                tick_c;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic                ack_q, ack_d;
    logic [LED_NUM-1:0]  led_q, led_d, pat_c;
    logic                dim_ok_c;

    logic [2:0]          mode_q  [LED_NUM];
    logic [2:0]          mode_d  [LED_NUM];
    logic [CNT_W-1:0]    arg_q   [LED_NUM];
    logic [CNT_W-1:0]    arg_d   [LED_NUM];
    logic [CNT_W-1:0]    cnt_q   [LED_NUM];
    logic [CNT_W-1:0]    cnt_d   [LED_NUM];
    logic [CNT_W-1:0]    cnt_inc_c [LED_NUM];
    logic [CNT_W-1:0]    step_c  [LED_NUM];
    logic [1:0]          phase_q [LED_NUM];
    logic [1:0]          phase_d [LED_NUM];
    logic [3:0]          flash_q [LED_NUM];
    logic [3:0]          flash_d [LED_NUM];
    logic [PWM_BITS-1:0] duty_q  [LED_NUM];
    logic [PWM_BITS-1:0] duty_d  [LED_NUM];
    logic                up_q    [LED_NUM];
    logic                up_d    [LED_NUM];

    // Next-state: timebase, write capture, per-channel tick stepping, output pattern.
    // led_d is built from next-state values so led shows the state of the same cycle.
    always_comb begin
        tick_c   = (pre_q == PRE_W'(TICK_DIV - 1));
        pre_d    = tick_c ? '0 : pre_q + PRE_W'(1);
        pwm_d    = pwm_q + PWM_BITS'(1);
        ack_d    = cfg_wr && (32'(cfg_idx) < LED_NUM);
        pat_c    = '0;
`ifdef LED_DIM_EN
        dim_ok_c = (dim == DUTY_TOP) || (pwm_d < dim);
`else
        dim_ok_c = 1'b1;
`endif
        for (int i = 0; i < int'(LED_NUM); i++) begin
            mode_d[i]    = mode_q[i];
            arg_d[i]     = arg_q[i];
            cnt_d[i]     = cnt_q[i];
            phase_d[i]   = phase_q[i];
            flash_d[i]   = flash_q[i];
            duty_d[i]    = duty_q[i];
            up_d[i]      = up_q[i];
            cnt_inc_c[i] = cnt_q[i] + CNT_W'(1);
            step_c[i]    = (arg_q[i] == '0) ? CNT_W'(1) : arg_q[i];

            if (cfg_wr && (cfg_idx == 4'(i))) begin
                mode_d[i]  = cfg_mode;
                arg_d[i]   = cfg_arg;
                cnt_d[i]   = '0;
                phase_d[i] = PH_ON;
                flash_d[i] = '0;
                duty_d[i]  = '0;
                up_d[i]    = 1'b1;
            end else if (tick_c) begin
                case (mode_q[i])
                    MODE_BLINK: begin
                        if (cnt_inc_c[i] >= step_c[i]) begin
                            cnt_d[i]   = '0;
                            phase_d[i] = (phase_q[i] == PH_ON) ? PH_OFF : PH_ON;
                        end else begin
                            cnt_d[i] = cnt_inc_c[i];
                        end
                    end
                    MODE_CODE: begin
                        cnt_d[i] = cnt_inc_c[i];
                        case (phase_q[i])
                            PH_ON: if (cnt_inc_c[i] >= ON_T) begin
                                cnt_d[i]   = '0;
                                phase_d[i] = PH_OFF;
                            end
                            PH_OFF: if (cnt_inc_c[i] >= ON_T) begin
                                cnt_d[i] = '0;
                                if (5'(flash_q[i]) + 5'd1 >= 5'(arg_q[i][3:0])) begin
                                    phase_d[i] = PH_GAP;
                                    flash_d[i] = '0;
                                end else begin
                                    phase_d[i] = PH_ON;
                                    flash_d[i] = flash_q[i] + 4'd1;
                                end
                            end
                            default: if (cnt_inc_c[i] >= GAP_T) begin
                                cnt_d[i]   = '0;
                                phase_d[i] = PH_ON;
                            end
                        endcase
                    end
                    MODE_BREATHE: begin
                        if (cnt_inc_c[i] >= step_c[i]) begin
                            cnt_d[i] = '0;
                            if (up_q[i]) begin
                                duty_d[i] = duty_q[i] + PWM_BITS'(1);
                                if (duty_q[i] == DUTY_TOP - PWM_BITS'(1)) up_d[i] = 1'b0;
                            end else begin
                                duty_d[i] = duty_q[i] - PWM_BITS'(1);
                                if (duty_q[i] == PWM_BITS'(1)) up_d[i] = 1'b1;
                            end
                        end else begin
                            cnt_d[i] = cnt_inc_c[i];
                        end
                    end
                    default: ;
                endcase
            end

            case (mode_d[i])
                MODE_ON:      pat_c[i] = 1'b1;
                MODE_BLINK:   pat_c[i] = (phase_d[i] == PH_ON);
                MODE_CODE:    pat_c[i] = (arg_d[i][3:0] != 4'd0) && (phase_d[i] == PH_ON);
                MODE_BREATHE: pat_c[i] = (pwm_d < duty_d[i]);
                default:      pat_c[i] = 1'b0;
            endcase
        end
        led_d = pat_c & {LED_NUM{dim_ok_c}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
            pwm_q <= '0;
            ack_q <= 1'b0;
            led_q <= '0;
            for (int i = 0; i < int'(LED_NUM); i++) begin
                mode_q[i]  <= '0;
                arg_q[i]   <= '0;
                cnt_q[i]   <= '0;
                phase_q[i] <= PH_ON;
                flash_q[i] <= '0;
                duty_q[i]  <= '0;
                up_q[i]    <= 1'b1;
            end
        end else begin
            pre_q <= pre_d;
            pwm_q <= pwm_d;
            ack_q <= ack_d;
            led_q <= led_d;
            for (int i = 0; i < int'(LED_NUM); i++) begin
                mode_q[i]  <= mode_d[i];
                arg_q[i]   <= arg_d[i];
                cnt_q[i]   <= cnt_d[i];
                phase_q[i] <= phase_d[i];
                flash_q[i] <= flash_d[i];
                duty_q[i]  <= duty_d[i];
                up_q[i]    <= up_d[i];
            end
        end
    end

    assign cfg_ack = ack_q;
    assign led     = led_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen: expected {cfg_ack, led} per cycle from an analytic tick model.
module tb_led_pattern_gen;

    localparam int NCH   = 4;
    localparam int PB    = 4;
    localparam int TDIV  = 10;
    localparam int ONT   = 2;
    localparam int GAPT  = 5;
    localparam int DTOP  = (1 << PB) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_wr;
    logic [3:0]    cfg_idx;
    logic [2:0]    cfg_mode;
    logic [15:0]   cfg_arg;
    logic          cfg_ack;
    logic [NCH-1:0] led;
`ifdef LED_DIM_EN
    logic [PB-1:0] dim;
`endif

    always #5 clk = ~clk;

    led_pattern_gen #(
        .CLK_FREQ_HZ(1000), .TICK_HZ(100), .LED_NUM(NCH), .PWM_BITS(PB),
        .CODE_ON_TICKS(ONT), .CODE_GAP_TICKS(GAPT)
    ) dut (
        .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_idx(cfg_idx),
        .cfg_mode(cfg_mode), .cfg_arg(cfg_arg),
`ifdef LED_DIM_EN
        .dim(dim),
`endif
        .cfg_ack(cfg_ack), .led(led)
    );

    int cyc;
    int checks;
    int errors;
    int rec_mode [NCH];
    int rec_arg  [NCH];
    int rec_w    [NCH];
    int dim_v;
    logic ack_e;
    logic [NCH:0] exp_q [$];
    logic [NCH:0] e;

    // Channel output at cycle c: ticks are counted from the first prescaler wrap after the write.
    function automatic logic exp_bit(int ch, int c);
        int t1, n, h, nf, p, k, d;
        t1 = rec_w[ch] + 1;
        while (t1 % TDIV != TDIV - 1) t1++;
        n = (c - 1 >= t1) ? (c - 1 - t1) / TDIV + 1 : 0;
        h = (rec_arg[ch] == 0) ? 1 : rec_arg[ch];
        case (rec_mode[ch])
            1: return 1'b1;
            2: return ((n / h) % 2) == 0;
            3: begin
                nf = rec_arg[ch] % 16;
                if (nf == 0) return 1'b0;
                p = n % (nf * 2 * ONT + GAPT);
                return (p < nf * 2 * ONT) && (((p / ONT) % 2) == 0);
            end
            4: begin
                k = (n / h) % (2 * DTOP);
                d = (k <= DTOP) ? k : 2 * DTOP - k;
                return (c % (DTOP + 1)) < d;
            end
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [NCH-1:0] exp_vec(int c);
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++)
            v[i] = exp_bit(i, c) & ((dim_v == DTOP) || ((c % (DTOP + 1)) < dim_v));
        return v;
    endfunction

    task automatic drive_write(int idx, int mode, int arg);
        cfg_wr   = 1'b1;
        cfg_idx  = 4'(idx);
        cfg_mode = 3'(mode);
        cfg_arg  = 16'(arg);
        if (idx < NCH) begin
            rec_mode[idx] = mode;
            rec_arg[idx]  = arg;
            rec_w[idx]    = cyc;
            ack_e         = 1'b1;
        end else begin
            ack_e = 1'b0;
        end
    endtask

    task automatic apply_reset();
        rst    = 1'b1;
        cfg_wr = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        cyc = 0;
        ack_e = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            rec_mode[i] = 0;
            rec_arg[i]  = 0;
            rec_w[i]    = 0;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({cfg_ack, led} !== '0) begin
            errors++;
            $display("FAIL reset_state cyc=%0d got=%b exp=%b", cyc, {cfg_ack, led}, {(NCH+1){1'b0}});
        end
        repeat (100) begin
            exp_q.push_back({ack_e, exp_vec(cyc + 1)});
            @(posedge clk); #1; cyc++;
            e = exp_q.pop_front(); checks++;
            if ({cfg_ack, led} !== e) begin
                errors++;
                $display("FAIL idle cyc=%0d got=%b exp=%b", cyc, {cfg_ack, led}, e);
            end
        end
    endtask

    task automatic test_mode(string name, int idx, int mode, int arg, int ncyc);
        drive_write(idx, mode, arg);
        repeat (ncyc) begin
            exp_q.push_back({ack_e, exp_vec(cyc + 1)});
            @(posedge clk); #1; cyc++;
            cfg_wr = 1'b0; ack_e = 1'b0;
            e = exp_q.pop_front(); checks++;
            if ({cfg_ack, led} !== e) begin
                errors++;
                $display("FAIL %s cyc=%0d got=%b exp=%b", name, cyc, {cfg_ack, led}, e);
            end
        end
    endtask

    task automatic test_invalid_idx();
        for (int k = 0; k < 2; k++) begin
            drive_write((k == 0) ? NCH : 15, 1, 7);
            repeat (10) begin
                exp_q.push_back({ack_e, exp_vec(cyc + 1)});
                @(posedge clk); #1; cyc++;
                cfg_wr = 1'b0; ack_e = 1'b0;
                e = exp_q.pop_front(); checks++;
                if ({cfg_ack, led} !== e) begin
                    errors++;
                    $display("FAIL invalid_idx cyc=%0d got=%b exp=%b", cyc, {cfg_ack, led}, e);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int idx_t [6];
        int mode_t [6];
        int arg_t [6];
        idx_t  = '{3, 3, 1, 2, 0, 2};
        mode_t = '{3, 3, 2, 6, 3, 4};
        arg_t  = '{3, 1, 0, 5, 0, 2};
        // land the first write on a prescaler wrap so write-over-tick priority is exercised
        while (cyc % TDIV != TDIV - 1) begin
            exp_q.push_back({ack_e, exp_vec(cyc + 1)});
            @(posedge clk); #1; cyc++;
            e = exp_q.pop_front(); checks++;
            if ({cfg_ack, led} !== e) begin
                errors++;
                $display("FAIL b2b_align cyc=%0d got=%b exp=%b", cyc, {cfg_ack, led}, e);
            end
        end
        for (int k = 0; k < 6 + 250; k++) begin
            if (k < 6) drive_write(idx_t[k], mode_t[k], arg_t[k]);
            exp_q.push_back({ack_e, exp_vec(cyc + 1)});
            @(posedge clk); #1; cyc++;
            cfg_wr = 1'b0; ack_e = 1'b0;
            e = exp_q.pop_front(); checks++;
            if ({cfg_ack, led} !== e) begin
                errors++;
                $display("FAIL back_to_back cyc=%0d got=%b exp=%b", cyc, {cfg_ack, led}, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        cfg_wr = 1'b1; cfg_idx = 4'd0; cfg_mode = 3'd1; cfg_arg = 16'd0;
        exp_q.push_back('0);
        @(posedge clk); #1;
        rst = 1'b0; cfg_wr = 1'b0; cyc = 0; ack_e = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            rec_mode[i] = 0; rec_arg[i] = 0; rec_w[i] = 0;
        end
        e = exp_q.pop_front(); checks++;
        if ({cfg_ack, led} !== e) begin
            errors++;
            $display("FAIL reset_mid cyc=%0d got=%b exp=%b", cyc, {cfg_ack, led}, e);
        end
        repeat (40) begin
            exp_q.push_back({ack_e, exp_vec(cyc + 1)});
            @(posedge clk); #1; cyc++;
            e = exp_q.pop_front(); checks++;
            if ({cfg_ack, led} !== e) begin
                errors++;
                $display("FAIL reset_mid_idle cyc=%0d got=%b exp=%b", cyc, {cfg_ack, led}, e);
            end
        end
    endtask

`ifdef LED_DIM_EN
    task automatic test_dim();
        apply_reset();
        dim = 4'd4; dim_v = 4;
        test_mode("dim_4", 0, 1, 0, 64);
        dim = 4'(DTOP); dim_v = DTOP;
        test_mode("dim_full", 1, 1, 0, 32);
    endtask
`endif

    initial begin
        checks = 0; errors = 0; cyc = 0; dim_v = DTOP; ack_e = 1'b0;
        rst = 1'b1; cfg_wr = 1'b0; cfg_idx = '0; cfg_mode = '0; cfg_arg = '0;
`ifdef LED_DIM_EN
        dim = 4'(DTOP);
`endif
        test_reset();
        test_mode("blink", 0, 2, 3, 150);
        test_mode("code", 1, 3, 2, 300);
        test_mode("breathe", 2, 4, 1, 400);
        test_invalid_idx();
        test_mode("override_on", 0, 1, 0, 80);
        test_back_to_back();
        test_reset_mid();
`ifdef LED_DIM_EN
        test_dim();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
